// File: rtl/muldiv_unit.sv
`timescale 1ns/1ps
// Iterative RV32M multiply/divide unit for the execute stage.
// 32-step shift-add multiply, restoring divide, fast path for /0 and overflow.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [2:0]     op;
  logic           sgn_a;
  logic           sgn_b;
  logic [W-1:0]   mag_a;
  logic [W-1:0]   mag_b;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic [5:0]     cnt;

  logic           a_signed;
  logic           b_signed;
  logic           neg_a;
  logic           neg_b;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           div0;
  logic           ovf;
  logic           fast;
  logic [W-1:0]   fast_res;

  logic [W:0]     sum;
  logic [W:0]     sh;
  logic [W:0]     diff;
  logic           ok;
  logic [W-1:0]   step_hi;
  logic [W-1:0]   step_lo;
  logic [W-1:0]   mulh;
  logic [W-1:0]   quo;
  logic [W-1:0]   rem;
  logic [W-1:0]   fin_res;

  assign a_signed = (Funct3 == 3'b001) | (Funct3 == 3'b010)
                  | (Funct3 == 3'b100) | (Funct3 == 3'b110);
  assign b_signed = (Funct3 == 3'b001) | (Funct3 == 3'b100)
                  | (Funct3 == 3'b110);
  assign neg_a = a_signed & SrcA[W-1];
  assign neg_b = b_signed & SrcB[W-1];
  assign in_a  = neg_a ? -SrcA : SrcA;
  assign in_b  = neg_b ? -SrcB : SrcB;

  assign div0 = Funct3[2] & (SrcB == '0);
  assign ovf  = Funct3[2] & ~Funct3[0]
              & (SrcA == {1'b1, {(W-1){1'b0}}})
              & (SrcB == '1);
  assign fast = div0 | ovf;

  always_comb begin
    fast_res = '0;
    if (div0)
      fast_res = Funct3[1] ? SrcA : '1;
    else if (!Funct3[1])
      fast_res = {1'b1, {(W-1){1'b0}}};
  end

  // Multiply keeps {product_hi, multiplier} in {hi, lo};
  // divide keeps {remainder, dividend/quotient} in {hi, lo}.
  assign sum  = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
  assign sh   = {hi, lo[W-1]};
  assign diff = sh - {1'b0, mag_b};
  assign ok   = ~diff[W];

  always_comb begin
    step_hi = sum[W:1];
    step_lo = {sum[0], lo[W-1:1]};
    if (op[2]) begin
      step_hi = ok ? diff[W-1:0] : sh[W-1:0];
      step_lo = {lo[W-2:0], ok};
    end
  end

  // High word of a 2W-bit negation: ~hi plus the carry out of ~lo + 1.
  assign mulh = (sgn_a ^ sgn_b)
              ? ~step_hi + {{(W-1){1'b0}}, (step_lo == '0)}
              : step_hi;
  assign quo = (sgn_a ^ sgn_b) ? -step_lo : step_lo;
  assign rem = sgn_a ? -step_hi : step_hi;

  always_comb begin
    fin_res = '0;
    unique case (1'b1)
      (op == 3'b000):              fin_res = step_lo;
      (!op[2] && op != 3'b000):    fin_res = mulh;
      (op[2:1] == 2'b10):          fin_res = quo;
      (op[2:1] == 2'b11):          fin_res = rem;
      default:                     fin_res = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (Start) state_nxt = fast ? FIN : CALC;
      CALC:    if (cnt == 6'd31) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op     <= '0;
      sgn_a  <= 1'b0;
      sgn_b  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      Result <= '0;
    end else begin
      if (state == IDLE && Start) begin
        op    <= Funct3;
        sgn_a <= neg_a;
        sgn_b <= neg_b;
        mag_a <= in_a;
        mag_b <= in_b;
        cnt   <= '0;
        hi    <= '0;
        lo    <= Funct3[2] ? in_a : in_b;
        if (fast)
          Result <= fast_res;
      end else if (state == CALC) begin
        hi  <= step_hi;
        lo  <= step_lo;
        cnt <= cnt + 6'd1;
        if (cnt == 6'd31)
          Result <= fin_res;
      end
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == FIN);

endmodule

// File: tb/tb_muldiv_unit.sv
`timescale 1ns/1ps
// Bench for muldiv_unit: vector table plus hand-written timing sequences.
// Expected results are queued at issue and popped when Done is seen.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .Funct3(Funct3),
    .SrcA(SrcA),
    .SrcB(SrcB),
    .Busy(Busy),
    .Done(Done),
    .Result(Result)
  );

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic bit is_fast(logic [2:0] f3, logic [31:0] a,
                                 logic [31:0] b);
    return f3[2] && (b == 0 ||
      (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  function automatic logic [31:0] ref_model(logic [2:0] f3,
                                            logic [31:0] a,
                                            logic [31:0] b);
    logic signed [63:0] xs, ys, yz;
    logic [63:0] xu, yu, p;
    logic signed [31:0] sa, sb;
    bit ov;
    xs = {{32{a[31]}}, a};
    ys = {{32{b[31]}}, b};
    yz = {32'b0, b};
    xu = {32'b0, a};
    yu = {32'b0, b};
    sa = a;
    sb = b;
    ov = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    case (f3)
      3'd0: begin p = xu * yu; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yz; return p[63:32]; end
      3'd3: begin p = xu * yu; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (ov) return 32'h80000000;
        return sa / sb;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'h0;
        return sa % sb;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic issue(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                       logic [31:0] e, output int n0);
    @(negedge clk);
    Start = 1'b1;
    Funct3 = f3;
    SrcA = a;
    SrcB = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    n0 = cyc;
    check("busy_rise", {31'b0, Busy}, 32'd1);
  endtask

  task automatic wait_done(string name, int n0, int lat, bit noise,
                           bit held);
    bit seen = 1'b0;
    bit busy_ok = 1'b1;
    logic [31:0] e;
    if (!held) Start = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (noise && k >= 3 && k < 8) begin
        Start = 1'b1;
        Funct3 = 3'($urandom);
        SrcA = $urandom;
        SrcB = $urandom;
      end else if (noise) begin
        Start = 1'b0;
      end
      if (!Busy) busy_ok = 1'b0;
      if (Done) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        check(name, Result, e);
        check({name, "_lat"}, 32'(cyc - n0), 32'(lat));
        check({name, "_busy"}, {31'b0, busy_ok}, 32'd1);
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: no Done within 60 cycles, want Done", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else if (!held) begin
      @(negedge clk);
      check({name, "_done_pulse"}, {31'b0, Done}, 32'd0);
      check({name, "_idle"}, {31'b0, Busy}, 32'd0);
    end
  endtask

  initial begin
    int n0, n1, dcount;
    logic [2:0] f3;
    logic [31:0] a, b;

    reset = 1'b0;
    Start = 1'b0;
    Funct3 = '0;
    SrcA = '0;
    SrcB = '0;

    vecs[0]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2};
    vecs[8]  = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'd6, 32'd5,        32'd0,        32'd5};
    vecs[10] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    vecs[12] = '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[13] = '{3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};

    #1;
    check("rst_busy", {31'b0, Busy}, 32'd0);
    check("rst_done", {31'b0, Done}, 32'd0);
    check("rst_result", Result, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      issue(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].res, n0);
      wait_done($sformatf("vec%0d", i), n0,
                is_fast(vecs[i].f3, vecs[i].a, vecs[i].b) ? 0 : 32,
                1'b0, 1'b0);
    end

    for (int i = 0; i < 8; i++) begin
      f3 = 3'(i);
      a = $urandom;
      b = (i == 5) ? 32'd0 : $urandom;
      issue(f3, a, b, ref_model(f3, a, b), n0);
      wait_done($sformatf("rand%0d", i), n0,
                is_fast(f3, a, b) ? 0 : 32, 1'b0, 1'b0);
    end

    issue(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, n0);
    wait_done("ignore_start", n0, 32, 1'b1, 1'b0);

    issue(3'd5, 32'd100, 32'd7, 32'd14, n0);
    Funct3 = 3'd3;
    SrcA = 32'hFFFFFFFF;
    SrcB = 32'hFFFFFFFF;
    exp_q.push_back(32'hFFFFFFFE);
    wait_done("b2b_first", n0, 32, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("b2b_gap", {31'b0, Busy}, 32'd0);
    @(posedge clk);
    #1;
    n1 = cyc;
    check("b2b_accept", {31'b0, Busy}, 32'd1);
    check("b2b_interval", 32'(n1 - n0), 32'd34);
    wait_done("b2b_second", n1, 32, 1'b0, 1'b0);

    issue(3'd4, 32'd1000, 32'd3, 32'd333, n0);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'b0, Busy}, 32'd0);
    check("abort_done", {31'b0, Done}, 32'd0);
    check("abort_result", Result, 32'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (Done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'd0);

    issue(3'd0, 32'd3, 32'd4, 32'd12, n0);
    wait_done("post_reset_mul", n0, 32, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
